irq_timer_ctrl: RTL and testbench

IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

---
 rtl/irq_timer_ctrl_pkg.sv | 37 +++
 rtl/irq_timer_ctrl_timer32.sv | 50 +++++
 rtl/irq_timer_ctrl.sv | 100 ++++++++++
 tb/tb_irq_timer_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_timer_ctrl_pkg.sv
// Shared constants for the interrupt timer block and the CPU PC mux.
package irq_timer_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TCON_W = 3;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_XCNT = 4'hC;

  // TCON bit positions
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'b00,
    EXC_ILLOP = 2'b01,
    EXC_XADR  = 2'b10
  } exc_sel_e;

  localparam logic [DATA_W-1:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [DATA_W-1:0] XADR_VEC  = 32'h8000_0008;

  // PC override helper for the CPU next-PC mux
  function automatic logic [DATA_W-1:0] exc_next_pc(input exc_sel_e sel,
                                                    input logic [DATA_W-1:0] seq_pc);
    case (sel)
      EXC_ILLOP: exc_next_pc = ILLOP_VEC;
      EXC_XADR:  exc_next_pc = XADR_VEC;
      default:   exc_next_pc = seq_pc;
    endcase
  endfunction

endpackage

// File: rtl/irq_timer_ctrl_timer32.sv
// 32-bit up-counter TL with reload value TH and a reload pulse.
module timer32
  import irq_timer_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              th_we_i,
  input  logic              tl_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] th_o,
  output logic [DATA_W-1:0] tl_o,
  output logic              reload_o
);

  logic [DATA_W-1:0] th_q, th_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  logic              tl_max_c;

  assign tl_max_c = (tl_q == {DATA_W{1'b1}});
  // A software TL store overrides the reload, so no reload is reported then
  assign reload_o = en_i & tl_max_c & ~tl_we_i;

  // Next TH/TL: store has priority over counting and reload
  always_comb begin
    th_d = th_q;
    tl_d = tl_q;
    if (th_we_i) th_d = wdata_i;
    if (tl_we_i) begin
      tl_d = wdata_i;
    end else if (en_i) begin
      tl_d = tl_max_c ? th_q : tl_q + DATA_W'(1);
    end
  end

  // TH/TL registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q <= '0;
      tl_q <= '0;
    end else begin
      th_q <= th_d;
      tl_q <= tl_d;
    end
  end

  assign th_o = th_q;
  assign tl_o = tl_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt timer with TCON control, exception counter and
// exception vector select.
module irq_timer_ctrl
  import irq_timer_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] pc,
  input  logic              illop,
  output logic [1:0]        exc_sel,
  output logic              irq
);

  logic [TCON_W-1:0] tcon_q, tcon_d;
  logic [DATA_W-1:0] xcnt_q, xcnt_d;
  logic [DATA_W-1:0] th, tl;
  logic              hit_c, reload_c, status_set_c;
  logic              th_we_c, tl_we_c, tcon_we_c;
  logic [3:0]        off_c;
  exc_sel_e          exc_c;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign hit_c     = (addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]);
  assign off_c     = {addr[3:2], 2'b00};
  assign th_we_c   = we & hit_c & (off_c == OFF_TH);
  assign tl_we_c   = we & hit_c & (off_c == OFF_TL);
  assign tcon_we_c = we & hit_c & (off_c == OFF_TCON);

  timer32 u_timer32 (
    .clk      (clk),
    .reset    (reset),
    .en_i     (tcon_q[TCON_EN]),
    .th_we_i  (th_we_c),
    .tl_we_i  (tl_we_c),
    .wdata_i  (wdata),
    .th_o     (th),
    .tl_o     (tl),
    .reload_o (reload_c)
  );

  assign status_set_c = reload_c & tcon_q[TCON_IE];
  assign irq          = tcon_q[TCON_IE] & tcon_q[TCON_ST];

  // Exception select: illegal opcode first, timer only in user mode
  always_comb begin
    exc_c = EXC_NONE;
    if (reset)                 exc_c = EXC_NONE;
    else if (illop)            exc_c = EXC_ILLOP;
    else if (irq && !pc[31])   exc_c = EXC_XADR;
  end
  assign exc_sel = exc_c;

  // Next TCON/XCNT: software may only clear status, and a hardware set wins
  always_comb begin
    tcon_d = tcon_q;
    xcnt_d = xcnt_q;
    if (tcon_we_c) begin
      tcon_d[TCON_EN] = wdata[TCON_EN];
      tcon_d[TCON_IE] = wdata[TCON_IE];
      tcon_d[TCON_ST] = wdata[TCON_ST] & tcon_q[TCON_ST];
    end
    if (status_set_c) tcon_d[TCON_ST] = 1'b1;
    if (exc_c != EXC_NONE) xcnt_d = xcnt_q + DATA_W'(1);
  end

  // TCON and exception counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_q <= '0;
      xcnt_q <= '0;
    end else begin
      tcon_q <= tcon_d;
      xcnt_q <= xcnt_d;
    end
  end

  // Combinational load data for the CPU read mux
  always_comb begin
    rdata = '0;
    if (re && hit_c && !reset) begin
      case (off_c)
        OFF_TH:   rdata = th;
        OFF_TL:   rdata = tl;
        OFF_TCON: rdata = {{(DATA_W-TCON_W){1'b0}}, tcon_q};
        OFF_XCNT: rdata = xcnt_q;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Scoreboard bench for irq_timer_ctrl: directed scenarios plus random traffic
// against a register-level reference model.
module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, pc, rdata;
  logic        we, re, illop, irq;
  logic [1:0]  exc_sel;

  always #5 clk = ~clk;

  irq_timer_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .pc      (pc),
    .illop   (illop),
    .exc_sel (exc_sel),
    .irq     (irq)
  );

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  exc;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: the four architectural registers
  logic [31:0] m_th, m_tl, m_xcnt;
  logic [2:0]  m_tcon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [27:0] base_hi;
    base_hi = BASE[31:4];
    if (a[31:4] != base_hi) return 32'h0;
    case (a[3:2])
      2'd0:    return m_th;
      2'd1:    return m_tl;
      2'd2:    return {29'h0, m_tcon};
      default: return m_xcnt;
    endcase
  endfunction

  // One bus cycle: drive, predict the visible outputs, then advance the model at the edge
  task automatic cycle(input logic rst, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic il);
    exp_t        e;
    logic        pend, hit, tl_st, at_max, set_st;
    logic [1:0]  exc;
    logic [31:0] nxt_tl;
    logic [27:0] base_hi;
    reset = rst; we = w; re = r; addr = a; wdata = d; pc = p; illop = il;
    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_xcnt = 0;
    end
    pend = m_tcon[1] && m_tcon[2];
    if (rst)                exc = 2'b00;
    else if (il)            exc = 2'b01;
    else if (pend && !p[31]) exc = 2'b10;
    else                    exc = 2'b00;
    e.exc = exc;
    e.irq = pend;
    e.rd  = (r && !rst) ? m_read(a) : 32'h0;
    sb_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      base_hi = BASE[31:4];
      hit    = (a[31:4] == base_hi);
      tl_st  = w && hit && (a[3:2] == 2'd1);
      at_max = (m_tl == ALL1);
      if (tl_st)          nxt_tl = d;
      else if (m_tcon[0]) nxt_tl = at_max ? m_th : m_tl + 32'd1;
      else                nxt_tl = m_tl;
      set_st = m_tcon[0] && at_max && !tl_st && m_tcon[1];
      if (w && hit && a[3:2] == 2'd2)
        m_tcon = {(d[2] & m_tcon[2]) | set_st, d[1:0]};
      else
        m_tcon[2] = m_tcon[2] | set_st;
      if (w && hit && a[3:2] == 2'd0) m_th = d;
      m_tl = nxt_tl;
      if (exc != 2'b00) m_xcnt = m_xcnt + 32'd1;
    end
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [31:0] p);
    cycle(1'b0, 1'b1, 1'b0, BASE + {28'h0, off}, d, p, 1'b0);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] p, input logic il);
    cycle(1'b0, 1'b0, 1'b1, BASE + {28'h0, off}, 32'h0, p, il);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("rdata",   rdata,            mon_e.rd);
        chk("exc_sel", {30'h0, exc_sel}, {30'h0, mon_e.exc});
        chk("irq",     {31'h0, irq},     {31'h0, mon_e.irq});
      end
    end
  end

  initial begin
    reset = 1'b1; we = 0; re = 0; addr = 0; wdata = 0; pc = 0; illop = 0;
    m_th = 0; m_tl = 0; m_tcon = 0; m_xcnt = 0;
    @(posedge clk); #1;

    // Reset state, illop masked while in reset
    cycle(1'b1, 1'b0, 1'b1, BASE + 32'h8, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) rd(4'(i * 4), 32'h400, 1'b0);

    // Reload into TH with status set, then user-mode exception
    wr(4'h0, 32'hFFFF_FFF0, 32'h400);
    wr(4'h4, 32'hFFFF_FFFE, 32'h400);
    wr(4'h8, 32'h3, 32'h400);
    rd(4'h4, 32'h400, 1'b0);
    rd(4'h4, 32'h400, 1'b0);
    rd(4'h8, 32'h400, 1'b0);
    rd(4'hC, 32'h400, 1'b0);
    rd(4'hC, 32'h400, 1'b0);

    // Same in kernel mode: irq visible, no exception until user mode
    wr(4'h8, 32'h0, 32'h8000_0100);
    wr(4'h4, 32'hFFFF_FFFE, 32'h8000_0100);
    wr(4'h8, 32'h3, 32'h8000_0100);
    for (int i = 0; i < 4; i++) rd(4'hC, 32'h8000_0100, 1'b0);
    rd(4'hC, 32'h0000_0100, 1'b0);
    rd(4'hC, 32'h0000_0100, 1'b0);

    // illop priority in user and kernel mode
    rd(4'hC, 32'h0000_0010, 1'b1);
    rd(4'hC, 32'h8000_0010, 1'b1);

    // Software can only clear status; a coincident reload set wins
    wr(4'h8, 32'h0, 32'h8000_0000);
    wr(4'h8, 32'h7, 32'h8000_0000);
    rd(4'h8, 32'h8000_0000, 1'b0);
    wr(4'h4, 32'hFFFF_FFFE, 32'h8000_0000);
    rd(4'h4, 32'h8000_0000, 1'b0);
    wr(4'h8, 32'h3, 32'h8000_0000);
    rd(4'h8, 32'h8000_0000, 1'b0);

    // TL store beats reload and suppresses the status set
    wr(4'h8, 32'h3, 32'h8000_0000);
    wr(4'h4, 32'hFFFF_FFFE, 32'h8000_0000);
    rd(4'h4, 32'h8000_0000, 1'b0);
    wr(4'h4, 32'h5, 32'h8000_0000);
    rd(4'h4, 32'h8000_0000, 1'b0);
    rd(4'h8, 32'h8000_0000, 1'b0);

    // XCNT store is ignored; counting stops when disabled
    wr(4'hC, 32'hDEAD_BEEF, 32'h8000_0000);
    rd(4'hC, 32'h8000_0000, 1'b0);
    wr(4'h8, 32'h0, 32'h8000_0000);
    rd(4'h4, 32'h8000_0000, 1'b0);
    rd(4'h4, 32'h8000_0000, 1'b0);

    // Reset mid-count, reads return zero during reset and outside the window
    wr(4'h4, 32'h1234, 32'h0);
    wr(4'h8, 32'h7, 32'h0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b0, 1'b1, BASE + 32'(i * 4), 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) rd(4'(i * 4), 32'h0, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, d, p;
      int          sel;
      sel = $urandom_range(0, 5);
      if (sel < 4)       a = BASE + 32'(sel * 4);
      else if (sel == 4) a = BASE + 32'h10;
      else               a = $urandom;
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (sel == 2) d = 32'($urandom_range(0, 7));
      p = $urandom;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), a, d, p, ($urandom_range(0, 9) == 0));
    end

    rd(4'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
